rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

Parametrised reorder buffer and in-order commit unit; successor to the fixed 16-entry, dual-issue commit stage. Sits between rename/map (dispatch side), the execute writeback buses, and the RAT/free list (commit side). Tracks occupancy with a true count, supports configurable dispatch, writeback and commit widths, gives dispatch real back-pressure, and raises a precise exception flush with the faulting PC.

## Interface
- `ROB_DEPTH`, 16: number of entries; power of two, ≥ 4.
- `DISPATCH_W`, 2: entries allocated per cycle, maximum.
- `WB_W`, 2: writeback completion ports.
- `COMMIT_W`, 2: entries retired per cycle, maximum; ≤ `ROB_DEPTH`.
- `IDX_W`, `$clog2(ROB_DEPTH)`: entry index width; derived, do not override.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state immediately.
- `dispatch_valid`  in  `DISPATCH_W`: per-lane allocate request; any mask is legal.
- `dispatch_bus`  in  `DISPATCH_W` × `rob_dispatch_t`: arch_dest, phy_dest, old_phy_dest, rf_we, is_br, is_store, pc.
- `dispatch_ready`  out  1: high when free slots ≥ `DISPATCH_W`.
- `dispatch_idx`  out  `DISPATCH_W` × `IDX_W`: slot assigned to each valid lane this cycle.
- `wb_valid`  in  `WB_W`: completion strobe per port.
- `wb_bus`  in  `WB_W` × `rob_wb_t`: rob_idx, ex, exccode[4:0].
- `commit_valid`  out  `COMMIT_W`: lane k retires this cycle. The mask is always contiguous from lane 0.
- `commit_bus`  out  `COMMIT_W` × `rob_commit_t`: arch_dest, phy_dest, old_phy_dest, rf_we, pc.
- `flush`  out  1: precise exception at the head.
- `flush_pc`  out  32: PC of the faulting entry; valid while `flush` is high.
- `flush_exccode`  out  5: exception code; valid while `flush` is high.
- `rob_count`  out  `IDX_W+1`: current occupancy.

## Operation
- **State:**
  - `head` and `tail`, each `IDX_W` bits, wrap modulo `ROB_DEPTH`.
  - `count`, `IDX_W+1` bits.
  - Per entry: valid, done, ex, exccode, and the payload.
- **Dispatch:**
  - Accepted only when `dispatch_ready` is high. Lanes presenting valid while ready is low are dropped; upstream must hold them.
  - Valid lanes are compacted in lane order: the n-th valid lane goes to `tail+n`.
  - Slots are written with valid=1 and done=0. `tail` advances by popcount(`dispatch_valid`).
- **Writeback:**
  - Sets done, ex and exccode on slot `rob_idx`, but only if that slot is valid. Writeback to an invalid slot is ignored.
  - If two ports hit the same index in one cycle (illegal), the higher port wins.
- **Commit selection** (combinational), lane k = entry `head+k`. Lane k commits iff all of the following hold:
  - lanes 0..k−1 commit;
  - the entry is valid and done, with ex=0;
  - if k>0, the entry is not is_br and not is_store.
  - Consequence: branches and stores retire only in lane 0.
- **Flush:**
  - `flush` = head entry valid & done & ex.
  - While `flush` is high, `commit_valid` is 0.
  - At the clock edge: all valid bits clear, `head`=`tail`=0, `count`=0. Dispatch and writeback in that cycle are discarded.
  - An excepting entry at lane k>0 only blocks lanes ≥k; it becomes head and flushes on a later cycle.
- **Count:**
  - `count` ← `count` + n_dispatch − n_commit.
  - `dispatch_ready` uses the current `count` only; same-cycle commits are not credited (conservative).

## Timing
- Reset values:
  - `count`=0, `head`=`tail`=0, all valid bits 0.
  - `dispatch_ready`=1, `commit_valid`=0, `flush`=0, `rob_count`=0.
  - `flush_pc`=0, `flush_exccode`=0.
- `dispatch_idx` is combinational from `tail`, valid in the same cycle as the request.
- Writeback at edge t makes the entry commit-eligible in cycle t+1. `commit_valid` and `commit_bus` are combinational from head entries.
- Minimum dispatch-to-commit latency is 2 edges: allocate, then writeback.
- Full boundary: with `count` = `ROB_DEPTH`−`DISPATCH_W`+1, `dispatch_ready`=0 even if a commit occurs in that same cycle.
- Empty boundary: with `count`=0, `commit_valid`=0 and `flush`=0, regardless of stale payload.
- Pointers wrap from `ROB_DEPTH`−1 to 0 without a bubble. A lane may cross the wrap.
- `reset` asserted mid-operation clears all state asynchronously, without waiting for an edge. First dispatch is accepted on the first edge after deassertion.

## Structure
- `rob_pkg`:
  - `rob_dispatch_t`, `rob_wb_t`, `rob_commit_t`, `rob_entry_t`;
  - `exccode_t`;
  - a packed widths constant for PC (32) and physical register index (6).
- Sub-module `rob_commit_select`: pure combinational. Takes `COMMIT_W` head entries and produces the contiguous commit mask, the flush request and the commit count. It is instantiated once and is unit-testable alone.

## Test plan
- **Back-to-back fill and drain, defaults:**
  - Stimulus: dispatch 2/cycle for 7 cycles; complete all; stop dispatching.
  - Required: `rob_count`=14 and `dispatch_ready`=1; one more dispatch takes `rob_count` to 16 with ready=0; then 2 commits/cycle until empty, in PC order.
- **Wrap:**
  - Stimulus: pre-advance head and tail to 15; dispatch 2 lanes.
  - Required: `dispatch_idx`={15,0}; both commit in one cycle after completion.
- **Store in lane 1:**
  - Stimulus: head=ALU done, head+1=store done.
  - Required: `commit_valid`=2'b01 in cycle 1 and 2'b01 (the store) in cycle 2.
- **Precise exception:**
  - Stimulus: entries A (done), B (done, ex, code 0x0A, pc 0xBFC00100).
  - Required: cycle 1 commits A only; cycle 2 gives `flush`=1 with `flush_pc`=0xBFC00100 and `flush_exccode`=0x0A; next cycle `rob_count`=0.
- **Out-of-order completion:**
  - Stimulus: complete entries 3, 1, 2, 0 on successive cycles.
  - Required: no commit until entry 0 is done; then 2 per cycle, in order.
- **Async reset:**
  - Stimulus: assert `reset` mid-cycle with `rob_count`=9.
  - Required: `rob_count`=0 and `commit_valid`=0 before the next edge.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer and its commit selector.
package rob_pkg;

    // Packed width table: [15:8] = PC width, [7:0] = physical register index width.
    localparam logic [15:0] ROB_WIDTHS    = {8'd32, 8'd6};
    localparam int          PC_W          = int'(ROB_WIDTHS[15:8]);
    localparam int          PHY_W         = int'(ROB_WIDTHS[7:0]);
    localparam int          ARCH_W        = 5;
    localparam int          EXC_W         = 5;
    localparam int          ROB_IDX_MAX_W = 8;

    typedef logic [EXC_W-1:0] exccode_t;

    typedef struct packed {
        logic [ARCH_W-1:0] arch_dest;
        logic [PHY_W-1:0]  phy_dest;
        logic [PHY_W-1:0]  old_phy_dest;
        logic              rf_we;
        logic              is_br;
        logic              is_store;
        logic [PC_W-1:0]   pc;
    } rob_dispatch_t;

    // rob_idx is sized for the largest supported ROB; bits above IDX_W must be zero.
    typedef struct packed {
        logic [ROB_IDX_MAX_W-1:0] rob_idx;
        logic                     ex;
        exccode_t                 exccode;
    } rob_wb_t;

    typedef struct packed {
        logic [ARCH_W-1:0] arch_dest;
        logic [PHY_W-1:0]  phy_dest;
        logic [PHY_W-1:0]  old_phy_dest;
        logic              rf_we;
        logic [PC_W-1:0]   pc;
    } rob_commit_t;

    typedef struct packed {
        logic          valid;
        logic          done;
        logic          ex;
        exccode_t      exccode;
        rob_dispatch_t payload;
    } rob_entry_t;

    // Retirement-relevant status of one head-window entry.
    typedef struct packed {
        logic valid;
        logic done;
        logic ex;
        logic is_br;
        logic is_store;
    } rob_head_t;

endpackage

// File: rtl/rob_commit_select.sv
// Combinational in-order commit selection over the head window of the ROB.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  rob_head_t [COMMIT_W-1:0] i_head_stat,
    input  logic      [COMMIT_W-1:0] i_live,
    output logic      [COMMIT_W-1:0] o_commit_mask,
    output logic                     o_flush_req,
    output logic      [CNT_W-1:0]    o_commit_cnt
);

    logic w_run;

    // Contiguous mask: stop at the first lane that cannot retire; control ops only in lane 0.
    always_comb begin
        o_commit_mask = {COMMIT_W{1'b0}};
        o_commit_cnt  = CNT_W'(0);
        w_run         = 1'b1;
        o_flush_req   = i_live[0] & i_head_stat[0].valid & i_head_stat[0].done & i_head_stat[0].ex;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (w_run && i_live[k] && i_head_stat[k].valid && i_head_stat[k].done && !i_head_stat[k].ex &&
                ((k == 0) || (!i_head_stat[k].is_br && !i_head_stat[k].is_store))) begin
                o_commit_mask[k] = 1'b1;
                o_commit_cnt     = o_commit_cnt + CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Parametrised reorder buffer with compacting dispatch, writeback marking,
// in-order multi-lane commit and precise exception flush.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH  = 16,
    parameter int DISPATCH_W = 2,
    parameter int WB_W       = 2,
    parameter int COMMIT_W   = 2,
    parameter int IDX_W      = $clog2(ROB_DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic          [DISPATCH_W-1:0]      dispatch_valid,
    input  rob_dispatch_t [DISPATCH_W-1:0]      dispatch_bus,
    output logic                                dispatch_ready,
    output logic          [DISPATCH_W-1:0][IDX_W-1:0] dispatch_idx,
    input  logic          [WB_W-1:0]            wb_valid,
    input  rob_wb_t       [WB_W-1:0]            wb_bus,
    output logic          [COMMIT_W-1:0]        commit_valid,
    output rob_commit_t   [COMMIT_W-1:0]        commit_bus,
    output logic                                flush,
    output logic          [31:0]                flush_pc,
    output exccode_t                            flush_exccode,
    output logic          [IDX_W:0]             rob_count
);

    localparam int CNT_W  = $clog2(COMMIT_W + 1);
    localparam int DCNT_W = $clog2(DISPATCH_W + 1);

    rob_entry_t                  r_entries [ROB_DEPTH];
    logic [IDX_W-1:0]            r_head;
    logic [IDX_W-1:0]            r_tail;
    logic [IDX_W:0]              r_count;

    logic                        w_accept;
    logic [DCNT_W-1:0]           w_lane_cnt;
    logic [DCNT_W-1:0]           w_n_disp;
    rob_entry_t                  w_head_entry [COMMIT_W];
    rob_head_t  [COMMIT_W-1:0]   w_head_stat;
    logic       [COMMIT_W-1:0]   w_live;
    logic       [COMMIT_W-1:0]   w_commit_mask;
    logic                        w_flush;
    logic       [CNT_W-1:0]      w_n_commit;
    logic       [WB_W-1:0]       w_wb_hit;
    logic       [WB_W-1:0][IDX_W-1:0] w_wb_slot;

    // Ready uses current occupancy only; valid lanes are packed from tail in lane order.
    always_comb begin
        w_accept   = (int'(r_count) <= (ROB_DEPTH - DISPATCH_W));
        w_lane_cnt = DCNT_W'(0);
        for (int i = 0; i < DISPATCH_W; i++) begin
            dispatch_idx[i] = r_tail + IDX_W'(w_lane_cnt);
            if (dispatch_valid[i]) begin
                w_lane_cnt = w_lane_cnt + DCNT_W'(1);
            end else begin
                w_lane_cnt = w_lane_cnt;
            end
        end
        if (w_accept) begin
            w_n_disp = w_lane_cnt;
        end else begin
            w_n_disp = DCNT_W'(0);
        end
        dispatch_ready = w_accept;
    end

    // Head window gather; lanes beyond the occupancy are never live.
    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            w_head_entry[k] = r_entries[r_head + IDX_W'(k)];
            w_live[k]       = (r_count > (IDX_W + 1)'(k));
            w_head_stat[k]  = '{valid:    w_head_entry[k].valid,
                                done:     w_head_entry[k].done,
                                ex:       w_head_entry[k].ex,
                                is_br:    w_head_entry[k].payload.is_br,
                                is_store: w_head_entry[k].payload.is_store};
            commit_bus[k]   = '{arch_dest:    w_head_entry[k].payload.arch_dest,
                                phy_dest:     w_head_entry[k].payload.phy_dest,
                                old_phy_dest: w_head_entry[k].payload.old_phy_dest,
                                rf_we:        w_head_entry[k].payload.rf_we,
                                pc:           w_head_entry[k].payload.pc};
        end
    end

    rob_commit_select #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (CNT_W)
    ) u_select (
        .i_head_stat   (w_head_stat),
        .i_live        (w_live),
        .o_commit_mask (w_commit_mask),
        .o_flush_req   (w_flush),
        .o_commit_cnt  (w_n_commit)
    );

    // Commit/flush outputs; flush fields read as zero outside a flush.
    always_comb begin
        commit_valid = w_commit_mask;
        flush        = w_flush;
        rob_count    = r_count;
        if (w_flush) begin
            flush_pc      = w_head_entry[0].payload.pc;
            flush_exccode = w_head_entry[0].exccode;
        end else begin
            flush_pc      = 32'd0;
            flush_exccode = 5'd0;
        end
    end

    // Writeback only lands on an in-range, currently allocated slot.
    always_comb begin
        for (int p = 0; p < WB_W; p++) begin
            w_wb_slot[p] = wb_bus[p].rob_idx[IDX_W-1:0];
            w_wb_hit[p]  = wb_valid[p] && ((32'(wb_bus[p].rob_idx) >> IDX_W) == 32'd0) &&
                           r_entries[w_wb_slot[p]].valid;
        end
    end

    // ROB state; later writeback ports override earlier ones by assignment order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= IDX_W'(0);
            r_tail  <= IDX_W'(0);
            r_count <= (IDX_W + 1)'(0);
        end else if (w_flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_head  <= IDX_W'(0);
            r_tail  <= IDX_W'(0);
            r_count <= (IDX_W + 1)'(0);
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_commit_mask[k]) begin
                    r_entries[r_head + IDX_W'(k)].valid <= 1'b0;
                end
            end
            for (int p = 0; p < WB_W; p++) begin
                if (w_wb_hit[p]) begin
                    r_entries[w_wb_slot[p]].done    <= 1'b1;
                    r_entries[w_wb_slot[p]].ex      <= wb_bus[p].ex;
                    r_entries[w_wb_slot[p]].exccode <= wb_bus[p].exccode;
                end
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (w_accept && dispatch_valid[i]) begin
                    r_entries[dispatch_idx[i]] <= '{valid:   1'b1,
                                                    done:    1'b0,
                                                    ex:      1'b0,
                                                    exccode: 5'd0,
                                                    payload: dispatch_bus[i]};
                end
            end
            r_head  <= r_head + IDX_W'(w_n_commit);
            r_tail  <= r_tail + IDX_W'(w_n_disp);
            r_count <= r_count + (IDX_W + 1)'(w_n_disp) - (IDX_W + 1)'(w_n_commit);
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Randomized bench for rob_commit_unit against an in-order queue model of the ROB.
module tb_rob_commit_unit;
    import rob_pkg::*;

    localparam int D  = 16;
    localparam int DW = 2;
    localparam int WW = 2;
    localparam int CW = 2;
    localparam int IW = 4;

    logic                          clk;
    logic                          reset;
    logic          [DW-1:0]        dispatch_valid;
    rob_dispatch_t [DW-1:0]        dispatch_bus;
    logic                          dispatch_ready;
    logic          [DW-1:0][IW-1:0] dispatch_idx;
    logic          [WW-1:0]        wb_valid;
    rob_wb_t       [WW-1:0]        wb_bus;
    logic          [CW-1:0]        commit_valid;
    rob_commit_t   [CW-1:0]        commit_bus;
    logic                          flush;
    logic          [31:0]          flush_pc;
    exccode_t                      flush_exccode;
    logic          [IW:0]          rob_count;

    rob_commit_unit dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_bus   (dispatch_bus),
        .dispatch_ready (dispatch_ready),
        .dispatch_idx   (dispatch_idx),
        .wb_valid       (wb_valid),
        .wb_bus         (wb_bus),
        .commit_valid   (commit_valid),
        .commit_bus     (commit_bus),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .flush_exccode  (flush_exccode),
        .rob_count      (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rob_dispatch_t d;
        bit            done;
        bit            ex;
        logic [4:0]    code;
    } m_ent_t;

    m_ent_t      m_slot [D];
    bit          m_valid [D];
    int          q[$];
    int          m_tail;
    logic [31:0] pc_ctr;
    int          wb_idx [WW];
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
    endtask

    // One clock: drive at negedge, compare settled outputs, advance model at posedge.
    task automatic run_cycle(input int wb_pct, input int disp_pct);
        int          pend[$];
        int          nd;
        int          exp_commit;
        bit          exp_flush;
        bit          exp_ready;
        logic [CW-1:0] exp_mask;
        m_ent_t      e;

        for (int i = 0; i < DW; i++) begin
            dispatch_valid[i]               = ($urandom_range(99) < disp_pct);
            dispatch_bus[i].arch_dest       = 5'($urandom);
            dispatch_bus[i].phy_dest        = 6'($urandom);
            dispatch_bus[i].old_phy_dest    = 6'($urandom);
            dispatch_bus[i].rf_we           = 1'($urandom);
            dispatch_bus[i].is_br           = ($urandom_range(9) == 0);
            dispatch_bus[i].is_store        = ($urandom_range(9) == 0);
            dispatch_bus[i].pc              = pc_ctr;
            pc_ctr                          = pc_ctr + 32'd4;
        end
        foreach (q[j]) if (!m_slot[q[j]].done) pend.push_back(q[j]);
        for (int p = 0; p < WW; p++) begin
            wb_valid[p] = ($urandom_range(99) < wb_pct);
            if (pend.size() > 0 && $urandom_range(3) != 0)
                wb_idx[p] = pend[$urandom_range(pend.size() - 1)];
            else
                wb_idx[p] = $urandom_range(D - 1);
            wb_bus[p].rob_idx = 8'(wb_idx[p]);
            wb_bus[p].ex      = ($urandom_range(39) == 0);
            wb_bus[p].exccode = 5'($urandom);
        end
        #1;
        exp_ready = (q.size() <= D - DW);
        check_val("ready", 64'(dispatch_ready), 64'(exp_ready));
        check_val("count", 64'(rob_count), 64'(q.size()));
        nd = 0;
        for (int i = 0; i < DW; i++) begin
            if (dispatch_valid[i] && exp_ready) begin
                check_val("disp_idx", 64'(dispatch_idx[i]), 64'((m_tail + nd) % D));
                nd++;
            end
        end
        exp_flush = (q.size() > 0) && m_slot[q[0]].done && m_slot[q[0]].ex;
        exp_mask   = '0;
        exp_commit = 0;
        if (!exp_flush) begin
            for (int k = 0; k < CW; k++) begin
                if (k >= q.size()) break;
                e = m_slot[q[k]];
                if (!(e.done && !e.ex && (k == 0 || (!e.d.is_br && !e.d.is_store)))) break;
                exp_mask[k] = 1'b1;
                exp_commit++;
            end
        end
        check_val("commit_valid", 64'(commit_valid), 64'(exp_mask));
        check_val("flush", 64'(flush), 64'(exp_flush));
        if (exp_flush) begin
            check_val("flush_pc", 64'(flush_pc), 64'(m_slot[q[0]].d.pc));
            check_val("flush_exccode", 64'(flush_exccode), 64'(m_slot[q[0]].code));
        end
        for (int k = 0; k < exp_commit; k++) begin
            e = m_slot[q[k]];
            check_val("commit_bus",
                      64'({commit_bus[k].arch_dest, commit_bus[k].phy_dest, commit_bus[k].old_phy_dest,
                           commit_bus[k].rf_we, commit_bus[k].pc}),
                      64'({e.d.arch_dest, e.d.phy_dest, e.d.old_phy_dest, e.d.rf_we, e.d.pc}));
        end
        @(posedge clk);
        if (exp_flush) begin
            model_reset();
        end else begin
            repeat (exp_commit) m_valid[q.pop_front()] = 1'b0;
            for (int p = 0; p < WW; p++) begin
                if (wb_valid[p] && m_valid[wb_idx[p]]) begin
                    m_slot[wb_idx[p]].done = 1'b1;
                    m_slot[wb_idx[p]].ex   = wb_bus[p].ex;
                    m_slot[wb_idx[p]].code = wb_bus[p].exccode;
                end
            end
            if (exp_ready) begin
                for (int i = 0; i < DW; i++) begin
                    if (dispatch_valid[i]) begin
                        m_slot[m_tail].d    = dispatch_bus[i];
                        m_slot[m_tail].done = 1'b0;
                        m_slot[m_tail].ex   = 1'b0;
                        m_slot[m_tail].code = 5'd0;
                        m_valid[m_tail]     = 1'b1;
                        q.push_back(m_tail);
                        m_tail = (m_tail + 1) % D;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        pc_ctr         = 32'h0000_1000;
        reset          = 1'b1;
        dispatch_valid = '0;
        dispatch_bus   = '0;
        wb_valid       = '0;
        wb_bus         = '0;
        model_reset();
        #1;
        check_val("rst_count", 64'(rob_count), 64'd0);
        check_val("rst_ready", 64'(dispatch_ready), 64'd1);
        check_val("rst_commit", 64'(commit_valid), 64'd0);
        check_val("rst_flush", 64'(flush), 64'd0);
        check_val("rst_flush_pc", 64'(flush_pc), 64'd0);
        check_val("rst_exccode", 64'(flush_exccode), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to the top without completions, then drain.
        repeat (10) run_cycle(0, 100);
        repeat (30) run_cycle(100, 0);

        for (int c = 0; c < 3000; c++) begin
            case ((c / 150) % 3)
                0:       run_cycle(15, 90);
                1:       run_cycle(60, 50);
                default: run_cycle(90, 70);
            endcase
        end

        // Asynchronous reset in the middle of a cycle with a busy ROB.
        repeat (6) run_cycle(10, 100);
        dispatch_valid = '0;
        wb_valid       = '0;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_count", 64'(rob_count), 64'd0);
        check_val("async_commit", 64'(commit_valid), 64'd0);
        check_val("async_flush", 64'(flush), 64'd0);
        check_val("async_ready", 64'(dispatch_ready), 64'd1);
        model_reset();
        #1;
        reset = 1'b0;
        @(negedge clk);
        repeat (300) run_cycle(50, 70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
